// File: rtl/conv_framer_pkg.sv
// Shared types and constants for the convolution stream framer.
// Tag bits sit directly above the pixel field: {sof, eol, eof, pixel}.
package conv_framer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } framer_state_t;

    localparam int SOF_BIT = 2;
    localparam int EOL_BIT = 1;
    localparam int EOF_BIT = 0;

    function automatic int tag_word_width(input int pixel_width);
        return pixel_width + 3;
    endfunction

endpackage

// File: rtl/conv_tag_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged pixels.
// Pointers carry an extra wrap bit so occupancy spans 0..DEPTH.
module conv_tag_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the head being popped this cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/conv_stream_framer.sv
// Tags the bare convolution pixel stream with SOF/EOL/EOF and buffers it onto ready/valid.
// Optional CONV_FRAMER_STATS_EN adds drop_count and frame_count outputs.
//   state  | meaning
//   IDLE   | waiting for first pixel of a frame; next pixel is SOF, sizes latched
//   ACTIVE | inside a frame; counters track the pixel position
module conv_stream_framer
    import conv_framer_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 8,
    parameter int BUFFER_LENGTH = 2000,
    parameter int FIFO_DEPTH    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PIXEL_WIDTH-1:0]           in_pixel,
    input  logic                             in_valid,
    input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_column_size,
    input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_row_size,
    output logic [PIXEL_WIDTH-1:0]           out_pixel,
    output logic                             out_sof,
    output logic                             out_eol,
    output logic                             out_eof,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             overflow,
    output logic                             frame_done
`ifdef CONV_FRAMER_STATS_EN
    ,
    output logic [15:0]                      drop_count,
    output logic [15:0]                      frame_count
`endif
);

    localparam int SW = $clog2(BUFFER_LENGTH);
    localparam int WW = tag_word_width(PIXEL_WIDTH);
    localparam logic [SW-1:0] ONE = SW'(1);

    framer_state_t state, state_next;
    logic [SW-1:0] cols_q, rows_q, col_q, row_q;
    logic [SW-1:0] cur_cols, cur_rows;
    logic          tag_sof, tag_eol, tag_eof;
    logic [WW-1:0] word_in, word_out;
    logic          full, empty, pop, push, drop;

    always_comb begin
        cur_cols   = cols_q;
        cur_rows   = rows_q;
        state_next = state;
        if (state == IDLE) begin
            cur_cols = (frame_column_size == '0) ? ONE : frame_column_size;
            cur_rows = (frame_row_size == '0) ? ONE : frame_row_size;
        end
        tag_sof = (state == IDLE);
        tag_eol = (col_q == cur_cols - ONE);
        tag_eof = tag_eol && (row_q == cur_rows - ONE);
        if (in_valid) state_next = tag_eof ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cols_q <= '0;
            rows_q <= '0;
            col_q  <= '0;
            row_q  <= '0;
        end else begin
            state <= state_next;
            // Counters advance on drops too so later pixels keep their geometry.
            if (in_valid) begin
                if (state == IDLE) begin
                    cols_q <= cur_cols;
                    rows_q <= cur_rows;
                end
                if (tag_eof) begin
                    col_q <= '0;
                    row_q <= '0;
                end else if (tag_eol) begin
                    col_q <= '0;
                    row_q <= row_q + ONE;
                end else begin
                    col_q <= col_q + ONE;
                end
            end
        end
    end

    assign pop     = !empty && out_ready;
    assign push    = in_valid && (!full || pop);
    assign drop    = in_valid && full && !pop;
    assign word_in = {tag_sof, tag_eol, tag_eof, in_pixel};

    conv_tag_fifo #(
        .WIDTH (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (word_in),
        .dout  (word_out),
        .full  (full),
        .empty (empty)
    );

    assign out_valid = !empty;
    assign out_pixel = word_out[PIXEL_WIDTH-1:0];
    assign out_sof   = word_out[PIXEL_WIDTH+SOF_BIT];
    assign out_eol   = word_out[PIXEL_WIDTH+EOL_BIT];
    assign out_eof   = word_out[PIXEL_WIDTH+EOF_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (drop) overflow <= 1'b1;
            frame_done <= pop && out_eof;
        end
    end

`ifdef CONV_FRAMER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count  <= '0;
            frame_count <= '0;
        end else begin
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
            if (frame_done) frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_framer.sv
// Self-checking bench for conv_stream_framer: directed scenarios plus random traffic
// compared against a frame-index / queue reference model.
module tb_conv_stream_framer;

    localparam int PW    = 8;
    localparam int BL    = 2000;
    localparam int DEPTH = 16;
    localparam int SW    = $clog2(BL);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] in_pixel = '0;
    logic          in_valid = 1'b0;
    logic [SW-1:0] col_sz = '0;
    logic [SW-1:0] row_sz = '0;
    logic [PW-1:0] out_pixel;
    logic          out_sof, out_eol, out_eof, out_valid;
    logic          out_ready = 1'b0;
    logic          overflow, frame_done;
`ifdef CONV_FRAMER_STATS_EN
    logic [15:0]   drop_count, frame_count;
`endif

    conv_stream_framer #(
        .PIXEL_WIDTH   (PW),
        .BUFFER_LENGTH (BL),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .in_pixel          (in_pixel),
        .in_valid          (in_valid),
        .frame_column_size (col_sz),
        .frame_row_size    (row_sz),
        .out_pixel         (out_pixel),
        .out_sof           (out_sof),
        .out_eol           (out_eol),
        .out_eof           (out_eof),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .overflow          (overflow),
        .frame_done        (frame_done)
`ifdef CONV_FRAMER_STATS_EN
        ,
        .drop_count        (drop_count),
        .frame_count       (frame_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: expected FIFO contents as {sof, eol, eof, pixel}.
    logic [PW+2:0] mq[$];
    bit            m_ovf, m_fd, m_inframe;
    int            m_idx, m_cols, m_rows, m_drops, m_frames;
    int            checks = 0;
    int            errors = 0;
    int            n_xfer = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_ovf = 0; m_fd = 0; m_inframe = 0;
        m_idx = 0; m_cols = 1; m_rows = 1; m_drops = 0; m_frames = 0;
    endtask

    task automatic step(input bit v, input logic [PW-1:0] pix, input bit rdy);
        logic [PW+2:0] exp_w, w;
        bit pop, fdn, accept, eof;
        int col;
        in_valid  = v;
        in_pixel  = pix;
        out_ready = rdy;
        @(negedge clk);
        exp_w = (mq.size() != 0) ? mq[0] : '0;
        check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check("out_word", 32'({out_sof, out_eol, out_eof, out_pixel}), 32'(exp_w));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_done", 32'(frame_done), 32'(m_fd));
`ifdef CONV_FRAMER_STATS_EN
        check("drop_count", 32'(drop_count), 32'((m_drops > 65535) ? 65535 : m_drops));
        check("frame_count", 32'(frame_count), 32'(m_frames % 65536));
`endif
        if (out_valid && out_ready) n_xfer++;
        pop    = (mq.size() != 0) && rdy;
        fdn    = pop && mq[0][PW];
        accept = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (v) begin
            if (!m_inframe) begin
                m_cols    = (col_sz == 0) ? 1 : int'(col_sz);
                m_rows    = (row_sz == 0) ? 1 : int'(row_sz);
                m_idx     = 0;
                m_inframe = 1;
            end
            col = m_idx % m_cols;
            eof = (m_idx == m_cols * m_rows - 1);
            w   = {m_idx == 0, col == m_cols - 1, eof, pix};
            if (accept) mq.push_back(w);
            else begin
                m_ovf = 1;
                m_drops++;
            end
            if (eof) m_inframe = 0;
            else m_idx++;
        end
        m_fd = fdn;
        if (fdn) m_frames++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_word", 32'({out_sof, out_eol, out_eof, out_pixel}), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        do_reset();

        // 3x2 frame, pixels 1..6, consumer always ready
        col_sz = 3; row_sz = 2;
        for (int i = 1; i <= 6; i++) step(1'b1, PW'(i), 1'b1);
        drain(4);

        // 1x1 frame
        col_sz = 1; row_sz = 1;
        step(1'b1, 8'hAA, 1'b1);
        drain(3);

        // stalled consumer, 20 pixels into a 16-deep FIFO
        col_sz = 5; row_sz = 4;
        for (int i = 0; i < 20; i++) step(1'b1, PW'($urandom), 1'b0);
        n_xfer = 0;
        drain(18);
        check("stall_xfers", 32'(n_xfer), 32'd16);
        check("stall_overflow", 32'(overflow), 32'd1);
`ifdef CONV_FRAMER_STATS_EN
        check("stall_drops", 32'(drop_count), 32'd4);
`endif

        // full FIFO with a pop coinciding with in_valid
        do_reset();
        col_sz = 8; row_sz = 4;
        for (int i = 0; i < 16; i++) step(1'b1, PW'($urandom), 1'b0);
        step(1'b1, PW'($urandom), 1'b1);
        step(1'b0, '0, 1'b0);
        check("full_pop_overflow", 32'(overflow), 32'd0);
        drain(20);

        // reset mid-frame, then a clean 3x3 frame
        do_reset();
        col_sz = 3; row_sz = 3;
        for (int i = 0; i < 4; i++) step(1'b1, PW'(8'h10 + i), 1'b1);
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, PW'(8'h20 + i), 1'b1);
        drain(3);

        // back-to-back frames, sizes changed during frame 1
        do_reset();
        col_sz = 2; row_sz = 2;
        step(1'b1, 8'h31, 1'b1);
        col_sz = 3; row_sz = 1;
        for (int i = 0; i < 3; i++) step(1'b1, PW'(8'h32 + i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, PW'(8'h40 + i), 1'b1);
        drain(3);

        // random traffic with random sizes and backpressure
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                col_sz = SW'($urandom_range(0, 4));
                row_sz = SW'($urandom_range(0, 4));
            end
            step($urandom_range(0, 4) != 0, PW'($urandom), $urandom_range(0, 3) != 0);
        end
        drain(DEPTH + 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
